// File: rtl/cache_controller_param_pkg.sv
// Shared definitions for the parametrised direct-mapped cache controller:
// state encoding, default geometry and address-field width helpers.
package cache_param_def;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_LINE_WORDS = 2;
    localparam int DEF_NUM_LINES  = 256;
    localparam int DEF_WRITE_EN   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITE_BACK,
        S_ALLOCATE,
        S_FLUSH_SCAN,
        S_FLUSH_WB
    } cache_state_e;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int addr_w, input int line_words, input int num_lines);
        return addr_w - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/cache_controller_param_line_store.sv
// Tag/valid/dirty/data storage for the direct-mapped cache. One shared index
// serves the combinational read and the write port; only valid/dirty reset.
module cache_line_store
    import cache_param_def::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int IDX_W      = idx_bits(DEF_NUM_LINES),
    parameter int TAG_W      = tag_bits(DEF_ADDR_W, DEF_LINE_WORDS, DEF_NUM_LINES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             idx,
    output logic                         rd_valid,
    output logic                         rd_dirty,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [DATA_W*LINE_WORDS-1:0] rd_line,
    input  logic [LINE_WORDS-1:0]        word_we,
    input  logic [DATA_W*LINE_WORDS-1:0] wr_line,
    input  logic                         fill,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic                         dirty_set,
    input  logic                         dirty_clr
);

    logic [TAG_W-1:0]             tag_mem  [NUM_LINES];
    logic [DATA_W*LINE_WORDS-1:0] data_mem [NUM_LINES];
    logic [NUM_LINES-1:0]         valid_q, valid_d;
    logic [NUM_LINES-1:0]         dirty_q, dirty_d;

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

    // A fill installs a clean line; dirty_set/dirty_clr never coincide with it.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
        if (dirty_set) dirty_d[idx] = 1'b1;
        if (dirty_clr) dirty_d[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) tag_mem[idx] <= wr_tag;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (word_we[w]) data_mem[idx][w*DATA_W +: DATA_W] <= wr_line[w*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/cache_controller_param.sv
// Direct-mapped cache controller: write-back/write-allocate or read-only,
// with a full-cache flush that writes back dirty lines in index order.
module cache_controller_param
    import cache_param_def::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int WRITE_EN   = DEF_WRITE_EN,
    localparam int LINE_W    = DATA_W * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_data,
    input  logic              cpu_req_rw,
    input  logic              cpu_req_valid,
    output logic [DATA_W-1:0] cpu_res_data,
    output logic              cpu_res_ready,
    output logic              busy,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_data,
    output logic              mem_req_rw,
    output logic              mem_req_valid,
    input  logic [LINE_W-1:0] mem_data,
    input  logic              mem_ready
);

    localparam int OFF_W = off_bits(LINE_WORDS);
    localparam int IDX_W = idx_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(ADDR_W, LINE_WORDS, NUM_LINES);

    cache_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              req_rw_q, req_rw_d;
    logic [IDX_W-1:0]  flush_ptr_q, flush_ptr_d;
    logic              gap_q, gap_d;

    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      st_idx;
    logic                  st_valid, st_dirty;
    logic [TAG_W-1:0]      st_tag;
    logic [LINE_W-1:0]     st_line;
    logic [LINE_WORDS-1:0] st_word_we;
    logic [LINE_W-1:0]     st_wr_line;
    logic                  st_fill, st_dirty_set, st_dirty_clr;
    logic                  hit;

    assign req_off = req_addr_q[OFF_W-1:0];
    assign req_idx = req_addr_q[OFF_W +: IDX_W];
    assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
    assign st_idx  = (state_q == S_FLUSH_SCAN || state_q == S_FLUSH_WB) ? flush_ptr_q : req_idx;
    assign hit     = st_valid && (st_tag == req_tag);
    assign busy    = (state_q != S_IDLE);

    cache_line_store #(
        .DATA_W    (DATA_W),
        .LINE_WORDS(LINE_WORDS),
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .idx      (st_idx),
        .rd_valid (st_valid),
        .rd_dirty (st_dirty),
        .rd_tag   (st_tag),
        .rd_line  (st_line),
        .word_we  (st_word_we),
        .wr_line  (st_wr_line),
        .fill     (st_fill),
        .wr_tag   (req_tag),
        .dirty_set(st_dirty_set),
        .dirty_clr(st_dirty_clr)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        req_rw_d      = req_rw_q;
        flush_ptr_d   = flush_ptr_q;
        gap_d         = 1'b0;
        cpu_res_data  = '0;
        cpu_res_ready = 1'b0;
        flush_done    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_rw    = 1'b0;
        mem_req_valid = 1'b0;
        st_word_we    = '0;
        st_wr_line    = '0;
        st_fill       = 1'b0;
        st_dirty_set  = 1'b0;
        st_dirty_clr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    flush_ptr_d = '0;
                    state_d     = S_FLUSH_SCAN;
                end else if (cpu_req_valid) begin
                    req_addr_d = cpu_req_addr;
                    req_data_d = cpu_req_data;
                    req_rw_d   = cpu_req_rw;
                    state_d    = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (req_rw_q && WRITE_EN == 0) begin
                    cpu_res_ready = 1'b1;
                    state_d       = S_IDLE;
                end else if (hit) begin
                    cpu_res_ready = 1'b1;
                    state_d       = S_IDLE;
                    if (req_rw_q) begin
                        st_word_we[req_off] = 1'b1;
                        st_wr_line          = {LINE_WORDS{req_data_q}};
                        st_dirty_set        = 1'b1;
                    end else begin
                        cpu_res_data = st_line[req_off*DATA_W +: DATA_W];
                    end
                end else if (st_valid && st_dirty) begin
                    state_d = S_WRITE_BACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {st_tag, req_idx, {OFF_W{1'b0}}};
                mem_req_data  = st_line;
                if (mem_ready) begin
                    gap_d   = 1'b1;
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                // gap_q holds the request low for one cycle after a write-back
                if (!gap_q) begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    if (mem_ready) begin
                        st_word_we = '1;
                        st_wr_line = mem_data;
                        st_fill    = 1'b1;
                        state_d    = S_COMPARE;
                    end
                end
            end
            S_FLUSH_SCAN: begin
                if (st_valid && st_dirty) begin
                    state_d = S_FLUSH_WB;
                end else if (flush_ptr_q == IDX_W'(NUM_LINES - 1)) begin
                    flush_done  = 1'b1;
                    flush_ptr_d = '0;
                    state_d     = S_IDLE;
                end else begin
                    flush_ptr_d = flush_ptr_q + IDX_W'(1);
                end
            end
            S_FLUSH_WB: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {st_tag, flush_ptr_q, {OFF_W{1'b0}}};
                mem_req_data  = st_line;
                if (mem_ready) begin
                    st_dirty_clr = 1'b1;
                    state_d      = S_FLUSH_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_rw_q    <= 1'b0;
            flush_ptr_q <= '0;
            gap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_rw_q    <= req_rw_d;
            flush_ptr_q <= flush_ptr_d;
            gap_q       <= gap_d;
        end
    end

endmodule

// File: tb/tb_cache_controller_param.sv
// Bench: a D-cache (index 0) and an I-cache (index 1) instance, each with a
// line memory responder; a word-level golden memory plus residency model.
module tb_cache_controller_param;

    typedef struct {
        int          g;
        logic        rw;
        logic [15:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_req_addr [2];
    logic [15:0] cpu_req_data [2];
    logic        cpu_req_rw [2];
    logic        cpu_req_valid [2];
    logic        flush_req [2];
    logic        mem_ready [2];
    logic [31:0] mem_data [2];
    logic [15:0] cpu_res_data [2];
    logic        cpu_res_ready [2];
    logic        busy [2];
    logic        flush_done [2];
    logic [15:0] mem_req_addr [2];
    logic [31:0] mem_req_data [2];
    logic        mem_req_rw [2];
    logic        mem_req_valid [2];

    logic [31:0] mem_line [2][32768];
    logic [15:0] gold [2][65536];
    bit          mv [2][256];
    bit          md [2][256];
    logic [6:0]  mt [2][256];
    int          mem_lat [2];
    txn_t        txn_q[$];
    txn_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cache_controller_param #(.WRITE_EN(1)) u_dc (
        .clk(clk), .rst(rst),
        .cpu_req_addr(cpu_req_addr[0]), .cpu_req_data(cpu_req_data[0]),
        .cpu_req_rw(cpu_req_rw[0]), .cpu_req_valid(cpu_req_valid[0]),
        .cpu_res_data(cpu_res_data[0]), .cpu_res_ready(cpu_res_ready[0]),
        .busy(busy[0]), .flush_req(flush_req[0]), .flush_done(flush_done[0]),
        .mem_req_addr(mem_req_addr[0]), .mem_req_data(mem_req_data[0]),
        .mem_req_rw(mem_req_rw[0]), .mem_req_valid(mem_req_valid[0]),
        .mem_data(mem_data[0]), .mem_ready(mem_ready[0])
    );

    cache_controller_param #(.WRITE_EN(0)) u_ic (
        .clk(clk), .rst(rst),
        .cpu_req_addr(cpu_req_addr[1]), .cpu_req_data(cpu_req_data[1]),
        .cpu_req_rw(cpu_req_rw[1]), .cpu_req_valid(cpu_req_valid[1]),
        .cpu_res_data(cpu_res_data[1]), .cpu_res_ready(cpu_res_ready[1]),
        .busy(busy[1]), .flush_req(flush_req[1]), .flush_done(flush_done[1]),
        .mem_req_addr(mem_req_addr[1]), .mem_req_data(mem_req_data[1]),
        .mem_req_rw(mem_req_rw[1]), .mem_req_valid(mem_req_valid[1]),
        .mem_data(mem_data[1]), .mem_ready(mem_ready[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mem_lat: -1 never answers, -2 random latency per request, else fixed.
    task automatic mem_responder(input int g);
        int cnt = 0;
        int lat = 0;
        forever begin
            @(negedge clk);
            mem_ready[g] = 1'b0;
            if (mem_req_valid[g] === 1'b1) begin
                if (cnt == 0) lat = (mem_lat[g] == -2) ? int'($urandom_range(0, 3)) : mem_lat[g];
                cnt++;
                if (lat >= 0 && cnt > lat) begin
                    if (mem_req_rw[g]) mem_line[g][mem_req_addr[g][15:1]] = mem_req_data[g];
                    else mem_data[g] = mem_line[g][mem_req_addr[g][15:1]];
                    txn_q.push_back('{g, mem_req_rw[g], mem_req_addr[g],
                                      mem_req_rw[g] ? mem_req_data[g] : mem_data[g]});
                    mem_ready[g] = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    initial mem_responder(0);
    initial mem_responder(1);

    // After reset the cache holds nothing, so the golden view is memory itself.
    task automatic reset_model();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 256; i++) begin
                mv[g][i] = 1'b0;
                md[g][i] = 1'b0;
            end
            for (int l = 0; l < 32768; l++) begin
                gold[g][2*l]   = mem_line[g][l][15:0];
                gold[g][2*l+1] = mem_line[g][l][31:16];
            end
        end
    endtask

    task automatic cmp_txns(input string what);
        chk({what, "_txn_count"}, txn_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++) begin
            chk({what, "_txn_rw"}, txn_q[i].rw, exp_q[i].rw);
            chk({what, "_txn_addr"}, txn_q[i].addr, exp_q[i].addr);
            chk({what, "_txn_data"}, txn_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic do_req(input int g, input logic [15:0] addr, input logic rw, input logic [15:0] wd,
                          output logic [15:0] rd, output int lat);
        logic [7:0]  idx;
        logic [6:0]  tag;
        logic [15:0] va;
        logic [15:0] exp_rd;
        int n;
        idx = addr[8:1];
        tag = addr[15:9];
        exp_q.delete();
        txn_q.delete();
        if (!(rw && g == 1)) begin
            if (!(mv[g][idx] && mt[g][idx] == tag)) begin
                if (mv[g][idx] && md[g][idx]) begin
                    va = {mt[g][idx], idx, 1'b0};
                    exp_q.push_back('{g, 1'b1, va, {gold[g][va+1], gold[g][va]}});
                end
                va = {tag, idx, 1'b0};
                exp_q.push_back('{g, 1'b0, va, {gold[g][va+1], gold[g][va]}});
                mv[g][idx] = 1'b1;
                mt[g][idx] = tag;
                md[g][idx] = 1'b0;
            end
            if (rw) begin
                gold[g][addr] = wd;
                md[g][idx]    = 1'b1;
            end
        end
        exp_rd = gold[g][addr];
        cpu_req_addr[g]  = addr;
        cpu_req_data[g]  = wd;
        cpu_req_rw[g]    = rw;
        cpu_req_valid[g] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            cpu_req_valid[g] = 1'b0;
        end while (cpu_res_ready[g] !== 1'b1 && n < 400);
        chk("req_completes", n < 400, 1'b1);
        rd  = cpu_res_data[g];
        lat = n;
        @(negedge clk);
        chk("ready_one_cycle", cpu_res_ready[g], 1'b0);
        if (!rw) chk("read_data", rd, exp_rd);
        cmp_txns("req");
        if (exp_q.size() == 0) chk("no_mem_latency", lat, 1);
    endtask

    task automatic do_flush(input int g, input bit with_req, output int cyc, output int rdy);
        logic [15:0] va;
        int n;
        int dones;
        exp_q.delete();
        txn_q.delete();
        for (int i = 0; i < 256; i++) begin
            if (mv[g][i] && md[g][i]) begin
                va = {mt[g][i], 8'(i), 1'b0};
                exp_q.push_back('{g, 1'b1, va, {gold[g][va+1], gold[g][va]}});
                md[g][i] = 1'b0;
            end
        end
        flush_req[g] = 1'b1;
        if (with_req) begin
            cpu_req_addr[g]  = 16'h0210;
            cpu_req_data[g]  = 16'h7777;
            cpu_req_rw[g]    = 1'b1;
            cpu_req_valid[g] = 1'b1;
        end
        n = 0; cyc = 0; rdy = 0; dones = 0;
        do begin
            @(negedge clk);
            n++;
            flush_req[g]     = 1'b0;
            cpu_req_valid[g] = 1'b0;
            if (n == 1) chk("flush_busy", busy[g], 1'b1);
            if (cpu_res_ready[g] === 1'b1) rdy++;
            if (flush_done[g] === 1'b1) dones++;
            if (busy[g] === 1'b1) cyc++;
        end while (busy[g] === 1'b1 && n < 5000);
        chk("flush_completes", n < 5000, 1'b1);
        chk("flush_done_once", dones, 1);
        cmp_txns("flush");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] rd;
        logic [15:0] a;
        logic [6:0]  ta;
        logic [7:0]  ix;
        int lat, cyc, rdy, n, bad;

        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cpu_req_addr[g] = '0; cpu_req_data[g] = '0; cpu_req_rw[g] = 1'b0;
            cpu_req_valid[g] = 1'b0; flush_req[g] = 1'b0;
            mem_lat[g] = 3;
            for (int l = 0; l < 32768; l++) mem_line[g][l] = $urandom;
            mem_line[g][8] = 32'hBEEF_1234;
        end
        reset_model();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset_ctrl_outputs", {busy[g], cpu_res_ready[g], flush_done[g], mem_req_valid[g],
                                       mem_req_rw[g], cpu_res_data[g], mem_req_addr[g]}, 64'h0);
            chk("reset_mem_data", mem_req_data[g], 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Cold miss then same-line hit.
        do_req(0, 16'h0010, 1'b0, 16'h0, rd, lat);
        chk("t1_miss_data", rd, 16'h1234);
        chk("t1_one_req", txn_q.size(), 1);
        if (txn_q.size() >= 1) chk("t1_req_addr_rw", {txn_q[0].rw, txn_q[0].addr}, {1'b0, 16'h0010});
        do_req(0, 16'h0011, 1'b0, 16'h0, rd, lat);
        chk("t1_hit_data", rd, 16'hBEEF);
        chk("t1_hit_latency", lat, 1);

        // Dirty victim is written back before the conflicting fill.
        do_req(0, 16'h0011, 1'b1, 16'hCAFE, rd, lat);
        do_req(0, 16'h0210, 1'b0, 16'h0, rd, lat);
        chk("t2_two_reqs", txn_q.size(), 2);
        if (txn_q.size() >= 2) begin
            chk("t2_wb", {txn_q[0].rw, txn_q[0].addr, txn_q[0].data}, {1'b1, 16'h0010, 32'hCAFE_1234});
            chk("t2_fill", {txn_q[1].rw, txn_q[1].addr}, {1'b0, 16'h0210});
        end

        // Read-only instance ignores writes.
        do_req(1, 16'h0010, 1'b0, 16'h0, rd, lat);
        do_req(1, 16'h0011, 1'b1, 16'h5555, rd, lat);
        chk("t3_wr_latency", lat, 1);
        do_req(1, 16'h0011, 1'b0, 16'h0, rd, lat);
        chk("t3_rd_unchanged", rd, 16'hBEEF);
        do_req(1, 16'h0210, 1'b0, 16'h0, rd, lat);
        chk("t3_no_wb", txn_q.size(), 1);
        if (txn_q.size() >= 1) chk("t3_fill_rw", txn_q[0].rw, 1'b0);

        // Flush with dirty lines at 0x08 and 0xFF.
        do_req(0, 16'h0210, 1'b1, 16'hABCD, rd, lat);
        do_req(0, 16'h01FE, 1'b1, 16'h4321, rd, lat);
        do_flush(0, 1'b0, cyc, rdy);
        chk("t4_two_writes", txn_q.size(), 2);
        if (txn_q.size() >= 2) begin
            chk("t4_first_idx08", txn_q[0].addr, 16'h0210);
            chk("t4_second_idxff", txn_q[1].addr, 16'h01FE);
        end

        // Second flush, colliding with a CPU request that must be dropped.
        do_flush(0, 1'b1, cyc, rdy);
        chk("t5_scan_cycles", cyc, 256);
        chk("t5_no_ready", rdy, 0);
        do_req(0, 16'h0210, 1'b0, 16'h0, rd, lat);
        chk("t5_write_dropped", rd, 16'hABCD);

        // Reset while a write-back waits on memory.
        do_req(0, 16'h0210, 1'b1, 16'h1111, rd, lat);
        mem_lat[0] = -1;
        txn_q.delete();
        cpu_req_addr[0] = 16'h0010; cpu_req_rw[0] = 1'b0; cpu_req_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            cpu_req_valid[0] = 1'b0;
            n++;
        end while (!(mem_req_valid[0] === 1'b1 && mem_req_rw[0] === 1'b1) && n < 50);
        chk("t6_wb_reached", n < 50, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_rst_mem_valid", mem_req_valid[0], 1'b0);
        chk("t6_rst_busy", busy[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        reset_model();
        mem_lat[0] = 3;
        @(negedge clk);
        do_req(0, 16'h0010, 1'b0, 16'h0, rd, lat);
        chk("t6_after_rst_data", rd, 16'h1234);
        chk("t6_only_fill", txn_q.size(), 1);
        if (txn_q.size() >= 1) chk("t6_fill_rw", txn_q[0].rw, 1'b0);

        // Random traffic over a few conflicting indices, then flush and compare memory.
        for (int g = 0; g < 2; g++) begin
            mem_lat[g] = -2;
            for (int k = 0; k < 60; k++) begin
                ta = 7'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: ix = 8'h08;
                    1: ix = 8'h09;
                    2: ix = 8'hFE;
                    default: ix = 8'hFF;
                endcase
                a = {ta, ix, 1'($urandom_range(0, 1))};
                do_req(g, a, 1'($urandom_range(0, 1)), 16'($urandom), rd, lat);
            end
            do_flush(g, 1'b0, cyc, rdy);
            if (g == 1) chk("ic_flush_cycles", cyc, 256);
            bad = 0;
            for (int l = 0; l < 32768; l++) begin
                if (mem_line[g][l] !== {gold[g][2*l+1], gold[g][2*l]}) bad++;
            end
            chk("mem_matches_golden", bad, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_controller_param.md
Name: cache_controller_param

Overview:
Parametrised successor to the 16-bit I-cache controller. Direct-mapped cache between CPU and memory, with configurable depth and line size. Supports write-back/write-allocate operation, or read-only (I-cache) operation selected by a parameter. Adds a full-cache flush: dirty lines are written back and every line stays valid.

Parameters:
ADDR_W, 16, word address width (CPU and memory both use 16-bit word addresses)
DATA_W, 16, CPU word width
LINE_WORDS, 2, words per line, power of 2 (>=2); memory bus width LINE_W = DATA_W*LINE_WORDS
NUM_LINES, 256, number of lines, power of 2
WRITE_EN, 1, 1 = write-back/write-allocate D-cache; 0 = read-only I-cache (writes acknowledged, no effect)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cpu_req_addr  in  ADDR_W  request word address
cpu_req_data  in  DATA_W  write data
cpu_req_rw  in  1  0 = read, 1 = write
cpu_req_valid  in  1  request valid (sampled only when busy=0)
cpu_res_data  out  DATA_W  read data
cpu_res_ready  out  1  one-cycle completion pulse
busy  out  1  high in every state except IDLE
flush_req  in  1  start flush (sampled only when busy=0)
flush_done  out  1  one-cycle pulse at flush end
mem_req_addr  out  ADDR_W  line-aligned word address (offset bits 0)
mem_req_data  out  LINE_W  write-back line
mem_req_rw  out  1  0 = read, 1 = write
mem_req_valid  out  1  memory request valid
mem_data  in  LINE_W  memory read line
mem_ready  in  1  memory completion; ignored when mem_req_valid=0

Behaviour:
- Address split: offset = log2(LINE_WORDS) LSBs; index = next log2(NUM_LINES) bits; tag = remaining bits. Word i of a line occupies bits [DATA_W*i +: DATA_W].
- Reset (rst=0, async): state IDLE, all valid/dirty bits 0, flush pointer 0. All outputs 0. Any in-flight memory request is abandoned immediately. Data and tag arrays are not reset.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - flush_req=1 -> FLUSH_SCAN with pointer 0. Flush has priority; a simultaneous cpu_req_valid is dropped.
  - else cpu_req_valid=1 -> latch addr/data/rw, go to COMPARE.
  - The CPU need only hold valid for one cycle.
- COMPARE: hit = valid && tag match.
  - Hit read: cpu_res_ready=1 and cpu_res_data = selected word this cycle, -> IDLE. Hit latency is 1 cycle after acceptance.
  - Hit write, WRITE_EN=1: update the word, set dirty, ready pulse, -> IDLE.
  - Write with WRITE_EN=0: ready pulse, no state change, no allocation on miss.
  - Miss: victim valid && dirty -> WRITE_BACK; otherwise -> ALLOCATE.
- WRITE_BACK:
  - Drive mem_req_valid=1, rw=1, addr={victim tag, index, 0}, data=victim line.
  - Outputs are held stable until mem_ready; then -> ALLOCATE.
- ALLOCATE:
  - Drive mem_req_valid=1, rw=0, addr={req tag, index, 0}.
  - On mem_ready: write line, set tag, valid=1, dirty=0, -> COMPARE (the request now hits).
- mem_req_valid deasserts the cycle after mem_ready. Back-to-back WRITE_BACK->ALLOCATE has one cycle with valid low.
- FLUSH_SCAN:
  - Line at pointer valid && dirty -> FLUSH_WB.
  - Otherwise: if pointer = NUM_LINES-1, pulse flush_done and -> IDLE; else increment pointer.
- FLUSH_WB: write-back as in WRITE_BACK. On mem_ready, clear dirty and return to FLUSH_SCAN at the same pointer; the line reads clean and the pointer advances.
- The flush pointer wraps to 0 at completion. With WRITE_EN=0 no line is ever dirty, so a flush takes exactly NUM_LINES scan cycles.
- Requests arriving while busy=1 are ignored; the CPU waits for cpu_res_ready.

Decomposition:
- Package cache_param_def:
  - cache_state_e enum (6 states)
  - default parameter constants
  - localparam helper functions for offset/index/tag widths
- Sub-module cache_line_store: tag, valid, dirty and data arrays. One combinational read port (index), one write port with per-word write enable plus line write. Valid/dirty bits are async-cleared on rst.

Test Plan:
1. Reset; read 0x0010; memory returns 0xBEEF1234 after 3 cycles -> one mem_req (addr 0x0010, rw=0); cpu_res_data=0x1234. Then read 0x0011 -> ready 1 cycle after acceptance, data 0xBEEF, no mem_req.
2. Write 0x0011=0xCAFE (hit), then read 0x0210 (same index 0x08, tag 1) -> mem write addr 0x0010 data 0xCAFE1234, then mem read addr 0x0210, then ready.
3. WRITE_EN=0: write 0x0011=0x5555 -> ready pulse; a later read of 0x0011 returns 0xBEEF; a conflict miss on index 0x08 issues no write-back.
4. Dirty lines at indices 0x08 and 0xFF; flush_req -> exactly two mem writes, index 0x08 first; flush_done pulses once. A second flush issues zero writes and takes 256 scan cycles.
5. flush_req and cpu_req_valid in the same IDLE cycle -> flush executes, busy=1, no cpu_res_ready for that request.
6. Drop rst low while WRITE_BACK is waiting on mem_ready -> mem_req_valid=0 immediately. After release, read 0x0010 misses and issues no write-back.
